// File: rtl/packet_buf_ctrl_pkg.sv
// packet_buf_ctrl_pkg: shared read-FSM encoding and default widths for the packet buffer controller
package packet_buf_ctrl_pkg;
    localparam int ADDR_BITS_DEF = 11;
    localparam int LEN_BITS_DEF  = 12;
    localparam int CNT_BITS_DEF  = 16;
    typedef enum logic [1:0] {RD_IDLE, RD_READ, RD_LAST} rd_state_e;
endpackage

// File: rtl/packet_buf_ctrl_rd_seq.sv
// packet_rd_seq: pops a length word, streams that many bytes from packet memory, then releases the space
module packet_rd_seq
    import packet_buf_ctrl_pkg::*;
#(
    parameter int pADDR_BITS = ADDR_BITS_DEF,
    parameter int pLEN_BITS  = LEN_BITS_DEF
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  rd_req_i,
    input  logic                  fq_empty_i,
    input  logic [pLEN_BITS-1:0]  fq_rdata_i,
    input  logic [7:0]            mem_rdata_i,
    output logic                  fq_rd_o,
    output logic [pADDR_BITS-1:0] mem_raddr_o,
    output logic [7:0]            tx_d_o,
    output logic                  tx_dv_o,
    output logic                  tx_last_o,
    output logic                  busy_o,
    output logic [pADDR_BITS:0]   rd_base_o
);
    rd_state_e state_q, state_d;
    logic [pADDR_BITS:0] rd_ptr_q, rd_ptr_d, rd_base_q, rd_base_d;
    logic [pLEN_BITS-1:0] rem_q, rem_d;
    logic issued_q;

    // Accept a packet in IDLE, issue one address per READ cycle, release the packet's space in LAST
    always_comb begin
        state_d   = state_q;
        rd_ptr_d  = rd_ptr_q;
        rd_base_d = rd_base_q;
        rem_d     = rem_q;
        fq_rd_o   = 1'b0;
        if (state_q == RD_IDLE) begin
            if (rd_req_i && !fq_empty_i) begin
                fq_rd_o  = 1'b1;
                rem_d    = fq_rdata_i;
                rd_ptr_d = rd_base_q;
                state_d  = RD_READ;
            end
        end else if (state_q == RD_READ) begin
            rd_ptr_d = rd_ptr_q + (pADDR_BITS+1)'(1);
            rem_d    = rem_q - pLEN_BITS'(1);
            state_d  = (rem_q <= pLEN_BITS'(1)) ? RD_LAST : RD_READ;
        end else begin
            rd_base_d = rd_ptr_q;
            state_d   = RD_IDLE;
        end
    end

    // State and pointer registers; issued_q marks that memory data returns this cycle
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= RD_IDLE;
            rd_ptr_q  <= '0;
            rd_base_q <= '0;
            rem_q     <= '0;
            issued_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            rd_ptr_q  <= rd_ptr_d;
            rd_base_q <= rd_base_d;
            rem_q     <= rem_d;
            issued_q  <= (state_q == RD_READ);
        end
    end

    assign mem_raddr_o = rd_ptr_q[pADDR_BITS-1:0];
    assign tx_dv_o     = issued_q;
    assign tx_d_o      = issued_q ? mem_rdata_i : 8'h00;
    assign tx_last_o   = (state_q == RD_LAST);
    assign busy_o      = (state_q != RD_IDLE);
    assign rd_base_o   = rd_base_q;
endmodule

// File: rtl/packet_buf_ctrl.sv
// packet_buf_ctrl: stores RX frames into packet memory, queues their lengths, drops frames that do not fit
module packet_buf_ctrl
    import packet_buf_ctrl_pkg::*;
#(
    parameter int pADDR_BITS = ADDR_BITS_DEF,
    parameter int pLEN_BITS  = LEN_BITS_DEF,
    parameter int pCNT_BITS  = CNT_BITS_DEF
) (
    input  logic                  iclk,
    input  logic                  i_rst,
    input  logic                  idv,
    input  logic [7:0]            irx_d,
    input  logic                  ird_req,
    input  logic                  ifq_empty,
    input  logic                  ifq_full,
    input  logic [pLEN_BITS-1:0]  ifq_rdata,
    input  logic [7:0]            imem_rdata,
    output logic                  ofq_wr,
    output logic [pLEN_BITS-1:0]  ofq_wdata,
    output logic                  ofq_rd,
    output logic                  omem_we,
    output logic [pADDR_BITS-1:0] omem_waddr,
    output logic [7:0]            omem_wdata,
    output logic [pADDR_BITS-1:0] omem_raddr,
    output logic [7:0]            otx_d,
    output logic                  otx_dv,
    output logic                  otx_last,
    output logic                  obusy,
    output logic [pCNT_BITS-1:0]  odrop_cnt
);
    localparam logic [pADDR_BITS:0] DEPTH = {1'b1, {pADDR_BITS{1'b0}}};

    logic [pADDR_BITS:0] wr_ptr_q, wr_ptr_d, wr_base_q, wr_base_d, rd_base, len;
    logic [pCNT_BITS-1:0] drop_cnt_q, drop_cnt_d;
    logic drop_q, drop_d, dv_q, mem_full, drop_now, frame_end;

    assign mem_full   = (wr_ptr_q - rd_base) == DEPTH;
    assign drop_now   = idv & ((~dv_q & ifq_full) | (dv_q & drop_q) | mem_full);
    assign frame_end  = dv_q & ~idv;
    assign len        = wr_ptr_q - wr_base_q;
    assign omem_we    = idv & ~drop_now;
    assign omem_waddr = wr_ptr_q[pADDR_BITS-1:0];
    assign omem_wdata = irx_d;
    assign ofq_wr     = frame_end & ~drop_q & (len != '0);
    assign ofq_wdata  = pLEN_BITS'(len);
    assign odrop_cnt  = drop_cnt_q;

    // Advance on stored bytes, roll back a dropped frame, commit the base on a pushed length
    always_comb begin
        wr_ptr_d   = (frame_end && drop_q) ? wr_base_q : omem_we ? wr_ptr_q + (pADDR_BITS+1)'(1) : wr_ptr_q;
        wr_base_d  = ofq_wr ? wr_ptr_q : wr_base_q;
        drop_d     = drop_now;
        drop_cnt_d = (frame_end && drop_q && drop_cnt_q != '1) ? drop_cnt_q + pCNT_BITS'(1) : drop_cnt_q;
    end

    // Write-side registers; drop_q holds the drop decision until the frame-end cycle
    always_ff @(posedge iclk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr_q   <= '0;
            wr_base_q  <= '0;
            drop_cnt_q <= '0;
            drop_q     <= 1'b0;
            dv_q       <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            wr_base_q  <= wr_base_d;
            drop_cnt_q <= drop_cnt_d;
            drop_q     <= drop_d;
            dv_q       <= idv;
        end
    end

    packet_rd_seq #(
        .pADDR_BITS(pADDR_BITS),
        .pLEN_BITS (pLEN_BITS)
    ) u_rd_seq (
        .clk_i      (iclk),
        .rst_i      (i_rst),
        .rd_req_i   (ird_req),
        .fq_empty_i (ifq_empty),
        .fq_rdata_i (ifq_rdata),
        .mem_rdata_i(imem_rdata),
        .fq_rd_o    (ofq_rd),
        .mem_raddr_o(omem_raddr),
        .tx_d_o     (otx_d),
        .tx_dv_o    (otx_dv),
        .tx_last_o  (otx_last),
        .busy_o     (obusy),
        .rd_base_o  (rd_base)
    );
endmodule

// File: tb/tb_packet_buf_ctrl.sv
// tb_packet_buf_ctrl: directed checks on a default-size and a 16-byte instance with memory/FIFO models
module tb_packet_buf_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic dv[2], rdreq[2], ffull[2];
    logic [7:0] rxd[2], txd[2];
    logic txdv[2], txlast[2], busy[2], fqrd[2], fqwr[2], mwe[2];
    logic [15:0] dropc[2];
    int we_cnt[2], push_cnt[2], last_waddr[2], last_len[2];
    logic [8:0] cap0[$], cap1[$];
    int errs = 0;
    int checks = 0;

    for (genvar g = 0; g < 2; g++) begin : h
        localparam int A = (g == 0) ? 11 : 4;
        localparam int L = A + 1;
        logic fq_empty, fq_full;
        logic [L-1:0] fq_wdata, fq_rdata;
        logic [A-1:0] waddr, raddr;
        logic [7:0] wdata, mrd;
        logic [7:0] mem [0:(1<<A)-1];
        logic [L-1:0] fifo [0:3];
        int head, tail, cnt;
        int wec = 0;
        int pc = 0;
        int lw = 0;
        int ll = 0;

        packet_buf_ctrl #(.pADDR_BITS(A), .pLEN_BITS(L), .pCNT_BITS(16)) dut (
            .iclk(clk), .i_rst(rst), .idv(dv[g]), .irx_d(rxd[g]), .ird_req(rdreq[g]),
            .ifq_empty(fq_empty), .ifq_full(fq_full), .ifq_rdata(fq_rdata), .imem_rdata(mrd),
            .ofq_wr(fqwr[g]), .ofq_wdata(fq_wdata), .ofq_rd(fqrd[g]), .omem_we(mwe[g]),
            .omem_waddr(waddr), .omem_wdata(wdata), .omem_raddr(raddr), .otx_d(txd[g]),
            .otx_dv(txdv[g]), .otx_last(txlast[g]), .obusy(busy[g]), .odrop_cnt(dropc[g]));

        assign fq_empty = (cnt == 0);
        assign fq_full  = (cnt == 4) || ffull[g];
        assign fq_rdata = fifo[head];

        always @(posedge clk) begin
            if (mwe[g]) mem[waddr] <= wdata;
            mrd <= mem[raddr];
        end

        always @(posedge clk or posedge rst) begin
            if (rst) begin
                head <= 0;
                tail <= 0;
                cnt  <= 0;
            end else begin
                if (fqwr[g]) begin
                    fifo[tail] <= fq_wdata;
                    tail <= (tail + 1) % 4;
                end
                if (fqrd[g]) head <= (head + 1) % 4;
                cnt <= cnt + int'(fqwr[g]) - int'(fqrd[g]);
            end
        end

        always @(posedge clk) begin
            if (mwe[g]) begin
                wec <= wec + 1;
                lw  <= int'(waddr);
            end
            if (fqwr[g]) begin
                pc <= pc + 1;
                ll <= int'(fq_wdata);
            end
        end

        assign we_cnt[g]     = wec;
        assign push_cnt[g]   = pc;
        assign last_waddr[g] = lw;
        assign last_len[g]   = ll;
    end

    always @(negedge clk) begin
        if (txdv[0]) cap0.push_back({txlast[0], txd[0]});
        if (txdv[1]) cap1.push_back({txlast[1], txd[1]});
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send(input int g, input int n, input int b0);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            dv[g]  = 1'b1;
            rxd[g] = 8'(b0 + i);
        end
        @(negedge clk);
        dv[g]  = 1'b0;
        rxd[g] = 8'h00;
        @(negedge clk);
    endtask

    task automatic rd_pkt(input int g, output int lat);
        int k;
        if (g == 0) cap0.delete(); else cap1.delete();
        @(negedge clk);
        rdreq[g] = 1'b1;
        #1;
        chk("accept", fqrd[g], 1);
        @(negedge clk);
        rdreq[g] = 1'b0;
        k = 1;
        while (!txdv[g] && k < 8) begin
            @(negedge clk);
            k++;
        end
        lat = k;
        k = 0;
        while (!(txdv[g] && txlast[g]) && k < 5000) begin
            @(negedge clk);
            k++;
        end
        chk("rd_done", k < 5000, 1);
        #1;
    endtask

    task automatic chk_pkt(input int g, input int n, input int b0);
        logic [8:0] q[$];
        int bad;
        bad = 0;
        if (g == 0) q = cap0; else q = cap1;
        chk("pkt_len", q.size(), n);
        for (int i = 0; i < q.size(); i++)
            if (q[i] !== {(i == n - 1), 8'(b0 + i)}) bad++;
        chk("pkt_bytes", bad, 0);
    endtask

    initial begin
        int lat, w0, p0, k;
        dv = '{1'b0, 1'b0};
        rdreq = '{1'b0, 1'b0};
        ffull = '{1'b0, 1'b0};
        rxd = '{8'h00, 8'h00};
        repeat (3) @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            chk("rst_busy", busy[g], 0);
            chk("rst_txdv", txdv[g], 0);
            chk("rst_txlast", txlast[g], 0);
            chk("rst_txd", txd[g], 0);
            chk("rst_drop", dropc[g], 0);
            chk("rst_fqwr", fqwr[g], 0);
            chk("rst_fqrd", fqrd[g], 0);
            chk("rst_we", mwe[g], 0);
        end
        rst = 1'b0;
        @(negedge clk);

        send(0, 64, 0);
        chk("we64", we_cnt[0], 64);
        chk("push64", push_cnt[0], 1);
        chk("len64", last_len[0], 64);
        rd_pkt(0, lat);
        chk("first_lat", lat, 2);
        chk_pkt(0, 64, 0);

        ffull[0] = 1'b1;
        w0 = we_cnt[0];
        p0 = push_cnt[0];
        send(0, 5, 8'h80);
        ffull[0] = 1'b0;
        chk("full_we", we_cnt[0] - w0, 0);
        chk("full_push", push_cnt[0] - p0, 0);
        chk("full_drop", dropc[0], 1);
        send(0, 3, 8'hA0);
        chk("after_drop_waddr", last_waddr[0], 66);
        chk("len3", last_len[0], 3);

        fork
            rd_pkt(0, lat);
            send(0, 20, 8'h40);
        join
        chk_pkt(0, 3, 8'hA0);
        chk("conc_len", last_len[0], 20);
        chk("conc_push", push_cnt[0], 3);
        rd_pkt(0, lat);
        chk_pkt(0, 20, 8'h40);

        send(0, 20, 8'h60);
        cap0.delete();
        @(negedge clk);
        rdreq[0] = 1'b1;
        @(negedge clk);
        rdreq[0] = 1'b0;
        k = 0;
        while (cap0.size() < 5 && k < 100) begin
            @(negedge clk);
            #1;
            k++;
        end
        chk("mid_rd_bytes", cap0.size(), 5);
        rst = 1'b1;
        #1;
        chk("arst_txdv", txdv[0], 0);
        chk("arst_busy", busy[0], 0);
        chk("arst_txd", txd[0], 0);
        chk("arst_last", txlast[0], 0);
        chk("arst_drop", dropc[0], 0);
        @(negedge clk);
        rst = 1'b0;
        send(0, 3, 8'h11);
        chk("restart_waddr", last_waddr[0], 2);
        chk("restart_len", last_len[0], 3);
        rd_pkt(0, lat);
        chk_pkt(0, 3, 8'h11);

        send(1, 10, 8'h10);
        chk("s_len10", last_len[1], 10);
        w0 = we_cnt[1];
        p0 = push_cnt[1];
        send(1, 10, 8'h30);
        chk("s_drop_we", we_cnt[1] - w0, 6);
        chk("s_drop_push", push_cnt[1] - p0, 0);
        chk("s_drop_cnt", dropc[1], 1);
        rd_pkt(1, lat);
        chk_pkt(1, 10, 8'h10);
        send(1, 16, 8'hC0);
        chk("s_len16", last_len[1], 16);
        chk("s_waddr16", last_waddr[1], 9);
        chk("s_drop_cnt2", dropc[1], 1);
        rd_pkt(1, lat);
        chk_pkt(1, 16, 8'hC0);

        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        send(1, 12, 8'h50);
        rd_pkt(1, lat);
        chk_pkt(1, 12, 8'h50);
        send(1, 12, 8'h70);
        chk("wrap_waddr", last_waddr[1], 7);
        chk("wrap_len", last_len[1], 12);
        rd_pkt(1, lat);
        chk_pkt(1, 12, 8'h70);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
